// File: rtl/div_sequencer.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU behind the E-stage stall.
// Optional DIV_EARLY_EXIT_EN: finish at once when |a| < |b|.
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             annul,
  output logic             div_ready,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic             neg_q;
  logic             neg_r;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic             b_zero;
  logic             early;
  logic             last;

  logic [WIDTH:0]   rem_sh;
  logic             fits;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] dvd_nxt;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign a_neg  = signed_div & a[WIDTH-1];
  assign b_neg  = signed_div & b[WIDTH-1];
  assign a_abs  = a_neg ? (~a + 1'b1) : a;
  assign b_abs  = b_neg ? (~b + 1'b1) : b;
  assign b_zero = (b == '0);

`ifdef DIV_EARLY_EXIT_EN
  assign early = (a_abs < b_abs);
`else
  assign early = 1'b0;
`endif

  assign last = (cnt == CW'(WIDTH - 1));

  // The shifted remainder needs one extra bit before the compare.
  assign rem_sh  = {rem, dvd[WIDTH-1]};
  assign fits    = (rem_sh >= {1'b0, dvs});
  assign rem_nxt = fits ? (rem_sh[WIDTH-1:0] - dvs)
                        : rem_sh[WIDTH-1:0];
  assign dvd_nxt = {dvd[WIDTH-2:0], fits};

  assign q_fix = neg_q ? (~dvd_nxt + 1'b1) : dvd_nxt;
  assign r_fix = neg_r ? (~rem_nxt + 1'b1) : rem_nxt;

  assign div_ready = (state == DONE);
  assign busy      = (state == BUSY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (annul) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            unique case (1'b1)
              b_zero:  state_nxt = DONE;
              early:   state_nxt = DONE;
              default: state_nxt = BUSY;
            endcase
          end
        end
        BUSY: begin
          if (last) begin
            state_nxt = DONE;
          end
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      rem   <= '0;
      dvd   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else if (!annul) begin
      unique case (state)
        IDLE: begin
          if (start) begin
            unique case (1'b1)
              b_zero: begin
                lo <= '1;
                hi <= a;
              end
              early: begin
                lo <= '0;
                hi <= a;
              end
              default: begin
                dvd   <= a_abs;
                dvs   <= b_abs;
                rem   <= '0;
                cnt   <= '0;
                neg_q <= a_neg ^ b_neg;
                neg_r <= a_neg;
              end
            endcase
          end
        end
        BUSY: begin
          rem <= rem_nxt;
          dvd <= dvd_nxt;
          cnt <= cnt + CW'(1);
          if (last) begin
            lo <= q_fix;
            hi <= r_fix;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Iterative 32-bit radix-2 divider with its control FSM; this is the resource behind the E-stage `div_ready` stall.
- The hazard unit holds E (stallE = div-op & ~div_ready) while this block iterates.
- Handles MIPS DIV/DIVU, divide-by-zero, operation-held-across-stall semantics, and annulment on exception flush.
- Produces {hi, lo} = {remainder, quotient} for the E→M pipeline register.

Parameters:
- WIDTH, 32, operand width; quotient and remainder are WIDTH each, iteration count = WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  E-stage instruction is DIV/DIVU; stays high for as long as E is stalled
- signed_div  input  1  1=DIV (two's complement), 0=DIVU; sampled with start in IDLE
- a  input  WIDTH  dividend (rs), sampled with start in IDLE
- b  input  WIDTH  divisor (rt), sampled with start in IDLE
- annul  input  1  flushE/exception; aborts any operation
- div_ready  output  1  one-cycle pulse; result valid
- busy  output  1  high in BUSY state
- hi  output  WIDTH  remainder
- lo  output  WIDTH  quotient

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset: state=IDLE, div_ready=0, busy=0, hi=0, lo=0, iteration counter=0.
- annul has priority over everything. If annul=1 at an edge:
  - next state=IDLE, div_ready=0 next cycle, hi/lo unchanged.
  - A start present in the same cycle is ignored.
- IDLE, start=1, b!=0:
  - Latch |a|, |b| (abs applied only when signed_div=1).
  - Latch the negate-quotient flag (sign(a) XOR sign(b)) and negate-remainder flag (sign(a)).
  - Clear the partial remainder; counter=0; next state=BUSY.
- IDLE, start=1, b==0:
  - lo=all-ones, hi=a (raw); next state=DONE. No exception is raised (MIPS undefined result).
- BUSY, each edge: one restoring step.
  - Shift {rem, dividend} left 1.
  - If rem >= divisor: subtract and set the quotient bit.
  - counter++.
  - On the edge where counter==WIDTH-1: write final lo/hi with sign fix-up (two's-complement negate per flags); next state=DONE.
- DONE: div_ready=1 for exactly this cycle; next state=IDLE unconditionally.
  - start is ignored in DONE, so a held start does not re-launch the same instruction.
- Latency: start first high in IDLE in cycle N → div_ready high in cycle N+33 (WIDTH+1). Divide-by-zero → ready in cycle N+1.
- Back-to-back DIVs: the pipeline advances on the ready cycle; the next DIV's start is seen in IDLE the following cycle and launches normally.
- hi/lo hold their last value after DONE until the next completion; they never change outside the completing edge.
- Overflow: signed 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0 (natural wrap, no flag).
- busy=1 exactly while state==BUSY.
- Reset mid-operation: same as annul, plus hi/lo cleared.

Optional Feature:
- Macro: DIV_EARLY_EXIT_EN.
- Defined: in IDLE with start=1, b!=0 and |a| < |b| (unsigned compare of the abs values):
  - lo=0, hi=a (raw, sign already correct); next state=DONE.
  - div_ready in cycle N+1.
- Undefined: such operations take the full WIDTH+1 latency with identical results.

Test Plan:
- DIVU a=100, b=7, start from cycle 5 held until ready → div_ready only in cycle 38; lo=14, hi=2; busy high cycles 6–37.
- DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0; DIVU a=5, b=0 → ready next cycle, lo=0xFFFFFFFF, hi=5.
- Abort and restart:
  - Start DIVU 1000/3; assert annul at 10 cycles in → state IDLE, no ready pulse, hi/lo keep the prior value.
  - Restart 1000/3 → lo=333, hi=1 after 33 cycles.
- Back-to-back: DIVU 9/2 then DIV 9/-2 with start continuously high → exactly two ready pulses, 34 cycles apart; results (4,1) then (0xFFFFFFFC,1).
- DIVU 3/10:
  - With DIV_EARLY_EXIT_EN: ready at N+1, lo=0, hi=3.
  - Without it: ready at N+33, same values.
